// File: rtl/pc8001_bus_pkg.sv
// Shared types for the PC-8001 main-RAM bus arbitration.
// Holds the arbiter state encoding and the RAM address width.
package pc8001_bus_pkg;

  localparam int RAM_AW = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_RELEASE,
    S_GAP
  } arb_state_e;

endpackage

// File: rtl/vram_bus_arbiter.sv
// CRTC row-fetch DMA responder: borrows the Z80 bus via BUSRQ/BUSAK
// and steers main RAM to the CRTC address while granted.
module vram_bus_arbiter
  import pc8001_bus_pkg::*;
#(
  parameter int REQ_TIMEOUT = 1023,
  parameter int RELEASE_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busreq,
  output logic              busack,
  input  logic [RAM_AW-1:0] ram_adr,
  output logic [7:0]        ram_data,
  output logic              cpu_busrq_n,
  input  logic              cpu_busak_n,
  input  logic [15:0]       cpu_adr,
  input  logic              cpu_mem_we,
  input  logic [7:0]        cpu_dout,
  output logic [RAM_AW-1:0] mem_adr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  output logic              dma_timeout
);

  localparam logic [9:0] WD_LAST = 10'(REQ_TIMEOUT - 1);

  arb_state_e state, state_nxt;
  logic [9:0] wd_cnt;
  logic [7:0] gap_cnt;
  logic       tmo_q;
  logic       gap_done;
  logic       granted;

  assign gap_done = (int'(gap_cnt) + 1) >= RELEASE_GAP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wd_cnt  <= '0;
      gap_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      // watchdog only flags; the FSM keeps waiting for BUSAK
      if (state == S_REQ) begin
        if (wd_cnt != '1)
          wd_cnt <= wd_cnt + 10'd1;
        if (wd_cnt == WD_LAST)
          tmo_q <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (state == S_GAP)
        gap_cnt <= gap_cnt + 8'd1;
      else
        gap_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (busreq)
          state_nxt = S_REQ;
      S_REQ:
        // a withdrawn request wins over a late BUSAK
        if (!busreq)
          state_nxt = S_RELEASE;
        else if (!cpu_busak_n)
          state_nxt = S_GRANT;
      S_GRANT:
        if (!busreq)
          state_nxt = S_RELEASE;
      S_RELEASE:
        if (cpu_busak_n)
          state_nxt = S_GAP;
      S_GAP:
        if (gap_done)
          state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    granted     = (state == S_GRANT);
    busack      = granted;
    cpu_busrq_n = !((state == S_REQ) || granted);
    mem_adr     = {1'b0, cpu_adr};
    mem_din     = cpu_dout;
    mem_we      = cpu_mem_we;
    if (granted) begin
      mem_adr = ram_adr;
      mem_we  = 1'b0;
    end
  end

  assign ram_data    = mem_dout;
  assign dma_timeout = tmo_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Scoreboard bench for vram_bus_arbiter with Z80, CRTC and RAM models.
// Read data is predicted from the RAM fill pattern plus logged CPU writes.
module tb_vram_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        busreq;
  logic        busack;
  logic [16:0] ram_adr;
  logic [7:0]  ram_data;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [15:0] cpu_adr;
  logic        cpu_mem_we;
  logic [7:0]  cpu_dout;
  logic [16:0] mem_adr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        dma_timeout;

  vram_bus_arbiter #(
    .REQ_TIMEOUT(1023),
    .RELEASE_GAP(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .busreq     (busreq),
    .busack     (busack),
    .ram_adr    (ram_adr),
    .ram_data   (ram_data),
    .cpu_busrq_n(cpu_busrq_n),
    .cpu_busak_n(cpu_busak_n),
    .cpu_adr    (cpu_adr),
    .cpu_mem_we (cpu_mem_we),
    .cpu_dout   (cpu_dout),
    .mem_adr    (mem_adr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .dma_timeout(dma_timeout)
  );

  int tests = 0;
  int fails = 0;
  int we_in_grant = 0;
  int ak_dly = 3;
  bit z80_hold = 0;

  logic [7:0] ram [0:131071];
  logic [7:0] wr_map [logic [16:0]];
  logic [7:0] sb [$];
  logic [7:0] exp_b;
  logic       cap;
  logic       cap_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)
      ram[mem_adr] <= mem_din;
    mem_dout <= ram[mem_adr];
  end

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [16:0] a);
    if (wr_map.exists(a))
      return wr_map[a];
    return a[7:0];
  endfunction

  // Z80: grants ak_dly cycles after BUSRQ, releases once BUSRQ drops
  initial begin
    int cnt;
    cnt = 0;
    cpu_busak_n = 1'b1;
    forever begin
      @(negedge clk);
      if (cpu_busrq_n) begin
        cpu_busak_n = 1'b1;
        cnt = 0;
      end else begin
        if (cnt >= ak_dly && !z80_hold)
          cpu_busak_n = 1'b0;
        cnt++;
      end
    end
  end

  always @(posedge clk) cap_d <= cap;

  always @(negedge clk) begin
    if (cap_d) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_b = sb.pop_front();
        check("row_byte", 32'(ram_data), 32'(exp_b));
      end
    end
    if (busack && mem_we)
      we_in_grant++;
  end

  task automatic get_grant();
    @(negedge clk);
    busreq = 1'b1;
    for (int i = 0; i < 200 && !busack; i++)
      @(negedge clk);
    check("grant_wait", 32'(busack), 32'd1);
  endtask

  task automatic fetch_row(input logic [16:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ram_adr = base + 17'(k);
      cap = 1'b1;
      sb.push_back(exp_byte(ram_adr));
      cpu_mem_we = 1'($urandom_range(0, 1));
      cpu_adr = 16'($urandom);
      cpu_dout = 8'($urandom);
      @(negedge clk);
      cap = 1'b0;
      cpu_mem_we = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic release_bus();
    @(negedge clk);
    busreq = 1'b0;
    @(negedge clk);
    check("rel_busack", 32'(busack), 32'd0);
    check("rel_busrq_n", 32'(cpu_busrq_n), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic rel_rereq(input bit do_wr);
    @(negedge clk);
    busreq = 1'b0;
    @(negedge clk);
    check("drop_busack", 32'(busack), 32'd0);
    check("drop_busrq_n", 32'(cpu_busrq_n), 32'd1);
    busreq = 1'b1;
    @(negedge clk);
    check("gap1_busrq_n", 32'(cpu_busrq_n), 32'd1);
    if (do_wr) begin
      cpu_adr = 16'h8000;
      cpu_dout = 8'h5A;
      cpu_mem_we = 1'b1;
      wr_map[17'h08000] = 8'h5A;
    end
    @(negedge clk);
    check("gap2_busrq_n", 32'(cpu_busrq_n), 32'd1);
    cpu_mem_we = 1'b0;
    @(negedge clk);
    check("idle_busrq_n", 32'(cpu_busrq_n), 32'd1);
    check("idle_busack", 32'(busack), 32'd0);
    @(negedge clk);
    check("rereq_busrq_n", 32'(cpu_busrq_n), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    bit          hit;
    for (int i = 0; i < 131072; i++)
      ram[i] = i[7:0];
    cap = 1'b0;
    reset = 1'b1;
    busreq = 1'b0;
    ram_adr = '0;
    cpu_adr = '0;
    cpu_mem_we = 1'b0;
    cpu_dout = '0;

    repeat (3) @(negedge clk);
    check("rst_busack", 32'(busack), 32'd0);
    check("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_timeout", 32'(dma_timeout), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a = 16'hF300 + 16'($urandom_range(0, 255));
      d = 8'($urandom);
      cpu_adr = a;
      cpu_dout = d;
      cpu_mem_we = 1'b1;
      wr_map[{1'b0, a}] = d;
      @(negedge clk);
      cpu_mem_we = 1'b0;
      check("cpu_mem_adr", 32'(mem_adr), 32'({1'b0, a}));
    end

    ak_dly = 3;
    @(negedge clk);
    busreq = 1'b1;
    ram_adr = 17'h0F300;
    @(negedge clk);
    check("busrq_fall", 32'(cpu_busrq_n), 32'd0);
    check("req_busack", 32'(busack), 32'd0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (!cpu_busak_n) begin
        hit = 1;
        check("grant_1cyc", 32'(busack), 32'd1);
      end else begin
        check("no_early_grant", 32'(busack), 32'd0);
      end
    end
    check("busak_seen", 32'(hit), 32'd1);
    @(negedge clk);
    check("grant_mem_adr", 32'(mem_adr), 32'h0F300);

    fetch_row(17'h0F300, 120);
    release_bus();

    for (int r = 0; r < 4; r++) begin
      ak_dly = $urandom_range(1, 6);
      get_grant();
      fetch_row(17'($urandom_range(0, 131000)),
                $urandom_range(8, 32));
      release_bus();
    end

    z80_hold = 1;
    @(negedge clk);
    busreq = 1'b1;
    @(negedge clk);
    check("wd_req_busrq_n", 32'(cpu_busrq_n), 32'd0);
    rel_rereq(0);
    z80_hold = 0;
    get_grant();
    fetch_row(17'h00100, 2);
    rel_rereq(1);
    get_grant();
    fetch_row(17'h07FFC, 8);
    release_bus();
    check("no_we_in_grant", 32'(we_in_grant), 32'd0);

    z80_hold = 1;
    @(negedge clk);
    busreq = 1'b1;
    @(negedge clk);
    check("wdog_in_req", 32'(cpu_busrq_n), 32'd0);
    for (int i = 0; i < 1100; i++) begin
      if (i == 1022)
        check("wdog_1022", 32'(dma_timeout), 32'd0);
      if (i == 1023)
        check("wdog_1023", 32'(dma_timeout), 32'd1);
      @(negedge clk);
    end
    z80_hold = 0;
    get_grant();
    fetch_row(17'h1F300, 4);
    release_bus();
    check("wdog_sticky", 32'(dma_timeout), 32'd1);

    get_grant();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rg_busack", 32'(busack), 32'd0);
    check("rg_busrq_n", 32'(cpu_busrq_n), 32'd1);
    check("rg_mem_we", 32'(mem_we), 32'd0);
    check("rg_timeout", 32'(dma_timeout), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rg_skip_gap", 32'(cpu_busrq_n), 32'd0);
    busreq = 1'b0;
    repeat (6) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
